// File: rtl/sync_event_rx.sv
// sync_event_rx: toggle-event synchronizer with per-channel pending counters and round-robin output; define SYNC_EVENT_RX_OVERFLOW_EN for sticky overflow flags.
module sync_event_rx #(
  parameter int NR_CHANNELS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_BITS = 4,
  localparam int CW = NR_CHANNELS > 1 ? $clog2(NR_CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NR_CHANNELS-1:0] toggle_in,
  output logic [NR_CHANNELS-1:0] event_pulse,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CW-1:0]          out_channel,
  output logic [NR_CHANNELS-1:0] overflow,
  input  logic [NR_CHANNELS-1:0] overflow_clr
);
  localparam int MW = $clog2(SYNC_STAGES + 2);
  localparam logic [MW-1:0] MASK_END = MW'(SYNC_STAGES + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  logic [NR_CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [NR_CHANNELS-1:0] hist_q;
  logic [MW-1:0] mask_q;
  logic [CNT_BITS-1:0] cnt_q [NR_CHANNELS];
  logic [CNT_BITS-1:0] cnt_d [NR_CHANNELS];
  logic [NR_CHANNELS-1:0] dec, ovf_set;
  logic [CW-1:0] sel_lo, sel_hi, sel;
  logic any_lo, any_hi, load;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
      mask_q <= '0;
    end else begin
      sync_q[0] <= toggle_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
      if (mask_q != MASK_END) mask_q <= mask_q + 1'b1;
    end

  // the mask swallows the edge seen when a level held through reset reaches the history flop
  assign event_pulse = mask_q == MASK_END ? sync_q[SYNC_STAGES-1] ^ hist_q : '0;

  // out_channel doubles as the last-loaded pointer; prefer the lowest busy channel above it, else wrap
  always_comb begin
    any_lo = 1'b0;
    any_hi = 1'b0;
    sel_lo = '0;
    sel_hi = '0;
    for (int i = NR_CHANNELS-1; i >= 0; i--)
      if (cnt_q[i] != '0) begin
        any_lo = 1'b1;
        sel_lo = CW'(i);
        if (i > int'(out_channel)) begin
          any_hi = 1'b1;
          sel_hi = CW'(i);
        end
      end
  end

  assign sel = any_hi ? sel_hi : sel_lo;
  assign load = !out_valid || out_ready;

  always_comb begin
    dec = '0;
    ovf_set = '0;
    for (int i = 0; i < NR_CHANNELS; i++) begin
      dec[i] = load && any_lo && sel == CW'(i);
      ovf_set[i] = event_pulse[i] && !dec[i] && cnt_q[i] == CNT_MAX;
      cnt_d[i] = event_pulse[i] == dec[i] || ovf_set[i] ? cnt_q[i] :
                 event_pulse[i] ? cnt_q[i] + 1'b1 : cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NR_CHANNELS; i++) cnt_q[i] <= '0;
      out_valid <= 1'b0;
      out_channel <= '0;
    end else begin
      for (int i = 0; i < NR_CHANNELS; i++) cnt_q[i] <= cnt_d[i];
      if (load) out_valid <= any_lo;
      if (load && any_lo) out_channel <= sel;
    end

`ifdef SYNC_EVENT_RX_OVERFLOW_EN
  logic [NR_CHANNELS-1:0] ovf_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) ovf_q <= '0;
    else ovf_q <= (ovf_q & ~overflow_clr) | ovf_set;

  assign overflow = ovf_q;
`else
  logic unused_ovf;

  assign unused_ovf = ^{ovf_set, overflow_clr};
  assign overflow = '0;
`endif
endmodule

// File: doc/sync_event_rx.md
SYNC_EVENT_RX -- requirements
Module: sync_event_rx

Interface
REQ-001 SHALL have parameter NR_CHANNELS, default 4: number of independent event channels, 1..16.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth per channel, 2..4.
REQ-003 SHALL have parameter CNT_BITS, default 4: width of the per-channel pending-event counter, 1..8.
REQ-004 SHALL have: clk  input  1  single clock; all logic in this domain.
REQ-005 SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have: toggle_in  input  NR_CHANNELS  per-channel toggle-encoded events from an unrelated domain; each level change is one event.
REQ-007 SHALL have: event_pulse  output  NR_CHANNELS  one-cycle pulse per detected event.
REQ-008 SHALL have: out_valid  output  1  a queued event is presented.
REQ-009 SHALL have: out_ready  input  1  consumer accepts the presented event.
REQ-010 SHALL have: out_channel  output  max(1,clog2(NR_CHANNELS))  channel index of the presented event.
REQ-011 SHALL have: overflow  output  NR_CHANNELS  sticky per-channel event-lost flags.
REQ-012 SHALL have: overflow_clr  input  NR_CHANNELS  per-channel clear for overflow.

Function
REQ-013 Each toggle_in bit SHALL pass through SYNC_STAGES flops, then one history flop; event = last stage XOR history.
REQ-014 A toggle captured at edge E SHALL raise event_pulse for exactly the cycle after edge E+SYNC_STAGES-1.
REQ-015 Event detection SHALL be masked for SYNC_STAGES+1 cycles after reset release, so a toggle_in level held through reset produces no event.
REQ-016 Each channel SHALL keep a pending counter: +1 on event, -1 when loaded into the output register, unchanged when both happen in the same cycle.
REQ-017 At counter value 2^CNT_BITS-1, an event without a simultaneous load SHALL be dropped; the counter holds, and overflow[i] is set.
REQ-018 The output register SHALL load when !out_valid or (out_valid and out_ready), using registered counter values only.
REQ-019 Load selection SHALL be round-robin: the first channel with a nonzero counter, searching from last loaded channel+1 and wrapping at NR_CHANNELS-1 to 0.
REQ-020 If no counter is nonzero at a load opportunity, out_valid SHALL deassert at that edge.
REQ-021 While out_valid=1 and out_ready=0, out_channel SHALL hold stable.
REQ-022 With out_ready held high and events pending, SHALL deliver one event per cycle.
REQ-023 An event pulsing in cycle c into an empty block SHALL give counter=1 from c+1 and out_valid=1 from c+2.
REQ-024 overflow_clr[i] SHALL clear overflow[i]; a simultaneous set SHALL win.

Reset
REQ-025 Reset SHALL clear all synchronizer, history, counter, round-robin pointer (points at channel 0 as last-loaded), out_valid and overflow state to 0 and start the REQ-015 mask.
REQ-026 During reset, outputs SHALL be: event_pulse=0, out_valid=0, out_channel=0, overflow=0.
REQ-027 Reset asserted mid-transfer SHALL discard pending and presented events without generating a handshake.

Configuration
REQ-028 Macro SYNC_EVENT_RX_OVERFLOW_EN SHALL control overflow tracking.
REQ-029 With SYNC_EVENT_RX_OVERFLOW_EN defined, overflow SHALL behave per REQ-017/REQ-024.
REQ-030 Without SYNC_EVENT_RX_OVERFLOW_EN, overflow SHALL be tied to 0, overflow_clr ignored, and counters still saturate silently.

Verification
REQ-031 Defaults; after mask, toggle ch2 0->1 at edge E -> event_pulse[2] single cycle after edge E+1; out_valid=1, out_channel=2 two cycles later.
REQ-032 toggle_in=4'b1111 held through reset -> no event_pulse, out_valid stays 0 after release.
REQ-033 out_ready=0; 3 toggles each on ch0,ch1,ch3 -> out_channel stays 0; then out_ready=1 -> sequence 0,1,3,0,1,3,0,1,3 on consecutive cycles, then out_valid=0.
REQ-034 CNT_BITS=2, out_ready=0; 5 events on ch1 -> counter=3, one presented, 1 lost, overflow[1]=1; overflow_clr[1] pulse -> 0; repeat without macro -> overflow stays 0.
REQ-035 Counter ch0 at 3, out_ready=1, event and load in same cycle -> counter remains 3, no overflow.
REQ-036 Assert reset with out_valid=1 and counters nonzero -> all outputs 0 immediately; no events delivered after release.
